// File: rtl/fir_seq_ctrl_pkg.sv
// Shared constants and state encoding for the FIR sequencer and its coefficient bank.
package fir_seq_ctrl_pkg;

   localparam int NTAP     = 11;
   localparam int DW       = 8;
   localparam int MAX_INFL = 4;

   localparam int INFL_W = $clog2(MAX_INFL + 1);
   localparam int DCNT_W = $clog2(NTAP);

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DRAIN = 3'd1,
      ST_FLUSH = 3'd2,
      ST_PURGE = 3'd3,
      ST_SWAP  = 3'd4
   } state_t;

endpackage

// File: rtl/fir_seq_ctrl_coef_bank.sv
// Shadow/active coefficient registers: writes go to the shadow, one strobe copies it into
// the active bank, which is presented packed to the FIR (H0 in the low byte).
module fir_seq_ctrl_coef_bank
   import fir_seq_ctrl_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_we,
   input  logic [3:0]         i_addr,
   input  logic [DW-1:0]      i_data,
   input  logic               i_swap,
   output logic [NTAP*DW-1:0] o_h
);

   logic [DW-1:0] r_shadow [NTAP];
   logic [DW-1:0] r_active [NTAP];

   // Addresses beyond the last tap match no slot and are silently dropped.
   for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_shadow[gi] <= '0;
            r_active[gi] <= '0;
         end else begin
            if (i_we && (i_addr == 4'(gi))) begin
               r_shadow[gi] <= i_data;
            end
            if (i_swap) begin
               r_active[gi] <= r_shadow[gi];
            end
         end
      end

      assign o_h[gi*DW +: DW] = r_active[gi];
   end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer in front of an 11-tap FIR: streams samples, and on commit drains, flushes the
// delay line with zeros, suppresses the flush results and then swaps coefficient banks.
module fir_seq_ctrl
   import fir_seq_ctrl_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cfg_we,
   input  logic [3:0]         i_cfg_addr,
   input  logic [DW-1:0]      i_cfg_data,
   input  logic               i_cfg_commit,
   output logic               o_cfg_busy,
   input  logic [DW-1:0]      i_s_din,
   input  logic               i_s_vin,
   output logic               o_s_ready,
   output logic [DW-1:0]      o_f_din,
   output logic               o_f_vin,
   output logic [NTAP*DW-1:0] o_f_h,
   input  logic [DW-1:0]      i_f_dout,
   input  logic               i_f_vout,
   output logic [DW-1:0]      o_m_dout,
   output logic               o_m_vout,
   output logic               o_err
);

   state_t              r_state;
   state_t              w_state_next;
   logic [INFL_W-1:0]   r_infl;
   logic [DCNT_W-1:0]   r_dcnt;
   logic [DCNT_W-1:0]   r_fcnt;
   logic [DW-1:0]       r_f_din;
   logic                r_f_vin;
   logic [DW-1:0]       r_m_dout;
   logic                r_m_vout;
   logic                r_busy;
   logic                r_err;
   logic                w_accept;
   logic                w_discard;
   logic                w_flush_entry;
   logic                w_swap;
   logic                w_flushing;

   assign o_s_ready  = (r_state == ST_RUN) && !i_rst;
   assign w_accept   = i_s_vin && o_s_ready;
   assign w_discard  = (r_dcnt != '0);
   assign w_flushing = (r_state == ST_FLUSH);

   fir_seq_ctrl_coef_bank u_bank (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_we   (i_cfg_we && !r_busy),
      .i_addr (i_cfg_addr),
      .i_data (i_cfg_data),
      .i_swap (w_swap),
      .o_h    (o_f_h)
   );

   // A sample still sitting in the F_VIN register counts as in flight for the drain tests.
   always_comb begin
      w_state_next  = r_state;
      w_flush_entry = 1'b0;
      w_swap        = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (i_cfg_commit) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((r_infl == '0) && !r_f_vin) begin
               w_state_next  = ST_FLUSH;
               w_flush_entry = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (r_fcnt == DCNT_W'(NTAP - 2)) w_state_next = ST_PURGE;
         end
         ST_PURGE: begin
            if ((r_dcnt == '0) && (r_infl == '0) && !r_f_vin) w_state_next = ST_SWAP;
         end
         ST_SWAP: begin
            w_swap       = 1'b1;
            w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_RUN;
         r_fcnt   <= '0;
         r_dcnt   <= '0;
         r_f_din  <= '0;
         r_f_vin  <= 1'b0;
         r_m_dout <= '0;
         r_m_vout <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_f_vin  <= w_accept || w_flushing;
         if (w_flushing) begin
            r_f_din <= '0;
         end else if (w_accept) begin
            r_f_din <= i_s_din;
         end
         r_m_dout <= i_f_dout;
         r_m_vout <= i_f_vout && !w_discard;
         if ((r_state == ST_RUN) && i_cfg_commit) begin
            r_busy <= 1'b1;
         end else if (w_swap) begin
            r_busy <= 1'b0;
         end
         if (w_flush_entry) begin
            r_fcnt <= '0;
         end else if (w_flushing) begin
            r_fcnt <= r_fcnt + 1'b1;
         end
         if (w_flush_entry) begin
            r_dcnt <= DCNT_W'(NTAP - 1);
         end else if (i_f_vout && w_discard) begin
            r_dcnt <= r_dcnt - 1'b1;
         end
      end
   end

   // In-flight tracking saturates at both ends and latches an error instead of wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_infl <= '0;
         r_err  <= 1'b0;
      end else if (r_f_vin && !i_f_vout) begin
         if (r_infl == INFL_W'(MAX_INFL)) r_err  <= 1'b1;
         else                             r_infl <= r_infl + 1'b1;
      end else if (i_f_vout && !r_f_vin) begin
         if (r_infl == '0) r_err  <= 1'b1;
         else              r_infl <= r_infl - 1'b1;
      end
   end

   assign o_f_din    = r_f_din;
   assign o_f_vin    = r_f_vin;
   assign o_m_dout   = r_m_dout;
   assign o_m_vout   = r_m_vout;
   assign o_cfg_busy = r_busy;
   assign o_err      = r_err;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench: behavioural 11-tap FIR behind the sequencer, plus a convolution
// reference model of what the sink must receive.
module tb_fir_seq_ctrl;

   localparam int NT = 11;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we, cfg_commit, cfg_busy;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic [7:0]  s_din;
   logic        s_vin, s_ready;
   logic [7:0]  f_din, f_dout;
   logic        f_vin, f_vout;
   logic [87:0] f_h;
   logic [7:0]  m_dout;
   logic        m_vout, err;

   always #5 clk = ~clk;

   fir_seq_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
      .i_cfg_commit(cfg_commit), .o_cfg_busy(cfg_busy),
      .i_s_din(s_din), .i_s_vin(s_vin), .o_s_ready(s_ready),
      .o_f_din(f_din), .o_f_vin(f_vin), .o_f_h(f_h),
      .i_f_dout(f_dout), .i_f_vout(f_vout),
      .o_m_dout(m_dout), .o_m_vout(m_vout), .o_err(err)
   );

   // ---------------- behavioural FIR (two-cycle latency, shares reset) ----------------
   logic [7:0] fir_dl [NT];
   logic [7:0] fir_s1_y, fir_y;
   logic       fir_s1_v, fir_v;
   logic       force_v = 1'b0;
   logic [7:0] force_d = 8'h00;

   function automatic logic [7:0] fir_calc(input logic [7:0] x);
      logic [31:0] acc;
      acc = 32'(f_h[7:0]) * 32'(x);
      for (int k = 1; k < NT; k++) acc += 32'(f_h[k*8 +: 8]) * 32'(fir_dl[k-1]);
      return acc[7:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NT; k++) fir_dl[k] <= 8'h00;
         fir_s1_y <= 8'h00; fir_s1_v <= 1'b0; fir_y <= 8'h00; fir_v <= 1'b0;
      end else begin
         if (f_vin) begin
            fir_dl[0] <= f_din;
            for (int k = 1; k < NT; k++) fir_dl[k] <= fir_dl[k-1];
            fir_s1_y <= fir_calc(f_din);
         end
         fir_s1_v <= f_vin;
         fir_y    <= fir_s1_y;
         fir_v    <= fir_s1_v;
      end
   end

   assign f_vout = fir_v | force_v;
   assign f_dout = force_v ? force_d : fir_y;

   // ---------------- reference model and scoreboard ----------------
   logic [7:0] m_shadow [NT];
   logic [7:0] m_active [NT];
   bit         m_busy;
   logic [7:0] hist [$];
   logic [7:0] exp_q [$];
   int         vectors = 0, miscompares = 0;
   int         n_fir_v = 0, n_m_v = 0, n_fh_chg = 0;
   bit         skip_sb = 1'b0;
   logic [87:0] prev_fh = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Results are a plain convolution over samples accepted since the last swap; anything
   // older is zero because the delay line was flushed.
   function automatic logic [7:0] ref_y();
      logic [31:0] s;
      int n;
      s = 0;
      n = hist.size();
      for (int k = 0; k < NT && k < n; k++) s += 32'(m_active[k]) * 32'(hist[n-1-k]);
      return s[7:0];
   endfunction

   function automatic logic [87:0] pack_active();
      logic [87:0] r;
      for (int k = 0; k < NT; k++) r[k*8 +: 8] = m_active[k];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NT; k++) begin m_shadow[k] = 8'h00; m_active[k] = 8'h00; end
      m_busy = 1'b0;
      hist.delete();
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (fir_v)  n_fir_v++;
         if (m_vout) n_m_v++;
         if (f_h !== prev_fh) n_fh_chg++;
         if (m_vout && !skip_sb) begin
            if (exp_q.size() == 0) chk("sb_pending", 0, 1);
            else                   chk("m_dout", m_dout, exp_q.pop_front());
         end
      end
      prev_fh <= f_h;
   end

   // One clock of stimulus; entered and left at posedge+1.
   task automatic drive(input logic vin, input logic [7:0] d, input logic we,
                        input logic [3:0] a, input logic [7:0] wd, input logic commit);
      logic exp_ready;
      s_vin = vin; s_din = d; cfg_we = we; cfg_addr = a; cfg_data = wd; cfg_commit = commit;
      exp_ready = !m_busy;
      @(negedge clk);
      chk("s_ready", s_ready, exp_ready);
      if (we && !m_busy && a < 4'(NT)) m_shadow[a] = wd;
      if (vin && exp_ready) begin
         hist.push_back(d);
         exp_q.push_back(ref_y());
      end
      if (commit && !m_busy) begin
         m_busy = 1'b1;
         for (int k = 0; k < NT; k++) m_active[k] = m_shadow[k];
         hist.delete();
      end
      @(posedge clk); #1;
      s_vin = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0);
   endtask

   task automatic wait_swap();
      int n;
      n = 0;
      @(negedge clk);
      chk("busy_set", cfg_busy, 1);
      while (cfg_busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("swap_done", cfg_busy, 0);
      m_busy = 1'b0;
      chk("f_h_swap", f_h, pack_active());
      chk("err_clear", err, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf0, nm0, nh0, cnt;
      logic [87:0] fh_old;

      rst = 1'b1; s_vin = 1'b1; s_din = 8'hA5;
      cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 8'h00; cfg_commit = 1'b0;
      model_reset();

      // Reset held three cycles with the source asserting valid.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_f_vin", f_vin, 0);
         chk("rst_f_h", f_h, 0);
         chk("rst_m_vout", m_vout, 0);
         chk("rst_busy", cfg_busy, 0);
         chk("rst_err", err, 0);
         @(posedge clk);
      end
      #1 rst = 1'b0; s_vin = 1'b0;

      // Identity filter, then a short stream.
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h01, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1);
      wait_swap();
      for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 4'd0, 8'h00, 1'b0);
      idle(6);

      // Bank swap committed mid-stream, samples offered while busy are dropped.
      nf0 = n_fir_v; nm0 = n_m_v; nh0 = n_fh_chg;
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 4'd1, 8'h02, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom_range(1, 255)), 1'b0, 4'd0, 8'h00, 1'b0);
      drive(1'b1, 8'h11, 1'b0, 4'd0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h99, 1'b0, 4'd0, 8'h00, 1'b0);
      wait_swap();
      idle(4);
      chk("suppressed", (n_fir_v - nf0) - (n_m_v - nm0), 10);
      chk("fh_changes", n_fh_chg - nh0, 1);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom_range(1, 100)), 1'b0, 4'd0, 8'h00, 1'b0);
      idle(6);

      // Write, commit and sample in the same cycle; write while busy; out-of-range address.
      drive(1'b1, 8'h33, 1'b1, 4'd3, 8'h05, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'hEE, 1'b0);
      wait_swap();
      chk("h3_written", f_h[31:24], 8'h05);
      chk("busy_write_dropped", f_h[7:0], 8'h00);
      drive(1'b0, 8'h00, 1'b1, 4'd12, 8'h77, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1);
      wait_swap();
      for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0, 4'd0, 8'h00, 1'b0);
      idle(6);

      // Random coefficient sets with a commit landing inside a random stream.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NT; k++) drive(1'b0, 8'h00, 1'b1, 4'(k), 8'($urandom), 1'b0);
         for (int i = 0; i < 10; i++)
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0, 4'd0, 8'h00, 1'(i == 6));
         wait_swap();
         for (int i = 0; i < 12; i++)
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b0, 4'd0, 8'h00, 1'b0);
         idle(6);
      end

      // Reset during PURGE aborts the swap.
      fh_old = f_h;
      drive(1'b0, 8'h00, 1'b1, 4'd0, 8'h07, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1);
      cnt = 0;
      for (int i = 0; i < 60 && cnt < 10; i++) begin
         @(negedge clk);
         if (f_vin) begin
            cnt++;
            chk("flush_zero", f_din, 0);
         end
      end
      chk("flush_count", cnt, 10);
      chk("no_early_swap", f_h, fh_old);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("abort_busy", cfg_busy, 0);
      chk("abort_f_h", f_h, 0);
      chk("abort_err", err, 0);
      chk("abort_ready", s_ready, 1);
      @(posedge clk); #1;
      drive(1'b1, 8'h42, 1'b0, 4'd0, 8'h00, 1'b0);
      idle(6);

      // Result with nothing in flight: error latches, result is still forwarded.
      skip_sb = 1'b1;
      force_v = 1'b1; force_d = 8'h5A;
      @(posedge clk); #1;
      force_v = 1'b0;
      @(negedge clk);
      chk("err_m_vout", m_vout, 1);
      chk("err_m_dout", m_dout, 8'h5A);
      chk("err_set", err, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", err, 1);
      skip_sb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("err_cleared", err, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
